pipe_shift_rotate_unit: RTL and testbench

- Parametrised successor to the datapath's fixed 8-bit mux / register / rotate chain.
- Selects one of NUM_IN input words, captures it, then applies a multi-step rotate or shift of programmable amount and direction, iteratively at one bit per clock.
- Adds a start/busy/done handshake and a held result register.
- Sits between the operand source registers and the result bus of the lab datapath.

---
 rtl/pipe_shift_rotate_unit.sv | 104 ++++++++++
 tb/tb_pipe_shift_rotate_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_shift_rotate_unit.sv
// Iterative shift/rotate unit: captures one of NUM_IN words, then applies
// amt single-bit ROL/ROR/SHL/ASR steps, one per clock, into a held result.
module pipe_shift_rotate_unit #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int AMT_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH*(2**SEL_W)-1:0]   in_data,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic [1:0]                    mode,
  input  logic [AMT_W-1:0]              amt,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              q
);

  localparam int NUM_IN = 2**SEL_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] remaining;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] work_next;

  function automatic logic [WIDTH-1:0] step_once(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       m
  );
    logic [WIDTH-1:0] r;
    r = w;
    unique case (m)
      2'b00: r = {w[WIDTH-2:0], w[WIDTH-1]};
      2'b01: r = {w[0], w[WIDTH-1:1]};
      2'b10: r = {w[WIDTH-2:0], 1'b0};
      2'b11: r = {w[WIDTH-1], w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Input channel mux.
  always_comb begin
    sel_word = in_data[WIDTH-1:0];
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One single-bit step of the latched operation.
  always_comb begin
    work_next = step_once(work, mode_r);
  end

  assign busy = (state != IDLE);

  // Control FSM, working register and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      mode_r    <= 2'b00;
      q         <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= sel_word;
            mode_r    <= mode;
            remaining <= amt;
            state     <= (amt != '0) ? STEP : FIN;
          end
        end
        STEP: begin
          work      <= work_next;
          remaining <= remaining - AMT_ONE;
          if (remaining == AMT_ONE) begin
            state <= FIN;
          end
        end
        FIN: begin
          q     <= work;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_shift_rotate_unit.sv
// Scoreboard bench for pipe_shift_rotate_unit: directed operations push
// expected results and completion cycles; a monitor checks each done pulse.
module tb_pipe_shift_rotate_unit;

  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam int AMT_W = 3;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] ROR = 2'b01;
  localparam logic [1:0] SHL = 2'b10;
  localparam logic [1:0] ASR = 2'b11;

  typedef struct {
    logic [WIDTH-1:0] q;
    int               cyc;
  } exp_t;

  logic                        clk;
  logic                        rst_n;
  logic [WIDTH*(2**SEL_W)-1:0] in_data;
  logic [SEL_W-1:0]            in_sel;
  logic [1:0]                  mode;
  logic [AMT_W-1:0]            amt;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic [WIDTH-1:0]            q;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   test_done;

  pipe_shift_rotate_unit #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W),
    .AMT_W(AMT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .mode(mode),
    .amt(amt),
    .start(start),
    .busy(busy),
    .done(done),
    .q(q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("q", 32'(q), 32'(e.q));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issue one op at the current negedge; return at its done cycle.
  task automatic run(input int sel, input logic [WIDTH-1:0] word,
                     input logic [1:0] md, input int am,
                     input logic [WIDTH-1:0] exp_q, input bit disturb);
    exp_t e;
    in_data[sel*WIDTH +: WIDTH] = word;
    in_sel = SEL_W'(sel);
    mode   = md;
    amt    = AMT_W'(am);
    start  = 1'b1;
    e.q    = exp_q;
    e.cyc  = cyc + am + 2;
    sb.push_back(e);
    for (int i = 1; i <= am + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb && i == 2) begin
        start   = 1'b1;
        in_sel  = SEL_W'(1);
        in_data = '1;
        mode    = SHL;
        amt     = AMT_W'(1);
      end
      check("busy_high", 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    test_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    mode      = ROL;
    amt       = '0;
    idle(2);
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    idle(1);

    run(2, 8'h81, ROL, 1, 8'h03, 1'b0);
    idle(2);

    // Mid-operation reset: ROL 0x81 by 7, abort after three steps.
    in_data[2*WIDTH +: WIDTH] = 8'h81;
    in_sel = 2'd2;
    mode   = ROL;
    amt    = 3'd7;
    start  = 1'b1;
    idle(1);
    start = 1'b0;
    idle(3);
    rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_q_hold", 32'(q), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    run(0, 8'h01, ROR, 3, 8'h20, 1'b0);
    run(1, 8'h80, ASR, 7, 8'hFF, 1'b0);
    run(2, 8'hFF, SHL, 4, 8'hF0, 1'b0);
    idle(1);
    run(3, 8'h5A, ROR, 0, 8'h5A, 1'b0);
    run(3, 8'h5A, ASR, 0, 8'h5A, 1'b0);
    run(3, 8'h5A, ROL, 7, 8'h2D, 1'b0);
    run(3, 8'h2D, ROL, 1, 8'h5A, 1'b0);
    run(0, 8'hFF, SHL, 7, 8'h80, 1'b0);
    run(1, 8'h7F, ASR, 7, 8'h00, 1'b0);
    run(2, 8'h81, ROR, 7, 8'h03, 1'b0);
    idle(3);
    check("q_holds", 32'(q), 32'h03);

    // Start while busy ignored, input changes ignored, then back-to-back.
    run(0, 8'h01, ROR, 3, 8'h20, 1'b1);
    run(2, 8'h0F, SHL, 1, 8'h1E, 1'b0);
    idle(4);
    check("q_final_hold", 32'(q), 32'h1E);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
